slice_stream: RTL and testbench
===============================

Name: slice_stream

Overview:
- Streaming, runtime-configurable bit slicer.
- Extracts an OUT_WIDTH-bit field from each DATA_WIDTH-bit input word. The offset, MSB/LSB reference and sign-extension mode are programmable at run time.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Sits between packetised datapath stages, e.g. to pull fields out of ADC sample words or headers without resynthesis.

Parameters:
- DATA_WIDTH, 32, input word width (>= 2).
- OUT_WIDTH, 8, output field width (1..DATA_WIDTH).
- OFFSET_WIDTH, 5, width of the offset field; must satisfy 2**OFFSET_WIDTH >= DATA_WIDTH.
- RESET_REL_MSB, 1, reset value of the active rel_msb mode bit.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- cfg_offset, input, OFFSET_WIDTH, requested slice offset.
- cfg_rel_msb, input, 1, 1 = offset counted from MSB, 0 = from LSB.
- cfg_sign_ext, input, 1, 1 = fill missing upper bits with in_data MSB (LSB mode only).
- cfg_load, input, 1, single-cycle strobe to load cfg_* into the active config.
- cfg_err, output, 1, one-cycle pulse when a load is rejected.
- in_data, input, DATA_WIDTH, input word.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, block can accept a word this cycle.
- out_data, output, OUT_WIDTH, sliced field.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts out_data.
- word_count, output, 16, count of words delivered (out_valid && out_ready); wraps 0xFFFF -> 0.

Behaviour:
Reset: asynchronous on rst=1.
- s1_valid=0, out_valid=0, out_data=0, cfg_err=0, word_count=0.
- Active config set to offset=0, rel_msb=RESET_REL_MSB, sign_ext=0.
- Reset mid-stream discards all in-flight words. in_ready is 1 on the first cycle after rst falls.

Configuration:
- cfg_load=1 with cfg_offset < DATA_WIDTH: active config updated at that edge.
- cfg_load=1 with cfg_offset >= DATA_WIDTH: active config unchanged; cfg_err=1 for exactly the next cycle.
- A word accepted in the same cycle as cfg_load uses the OLD config. Each word captures the active config into stage 1 with its data, so later loads never affect words in flight.

Slice rule (o = offset, N = DATA_WIDTH, M = OUT_WIDTH):
- LSB mode: out[i] = in[o+i] for o+i <= N-1. Missing bits (o+i > N-1) = in[N-1] if sign_ext, else 0.
- MSB mode: out[M-1-i] = in[N-1-o-i] for N-1-o-i >= 0. Missing low bits = 0; sign_ext ignored.
- Implementation: zero/sign-padded shift, no out-of-range indexing.

Pipeline/handshake:
- Stage 1 registers data + config. Stage 2 computes the slice and registers out_data/out_valid.
- s1_adv = s1_valid && (!out_valid || out_ready).
- in_ready = !s1_valid || s1_adv; this is combinational from out_ready, with no other comb paths.
- Accept on in_valid && in_ready.
- Latency: a word accepted at edge k appears on out_data after edge k+1 when unstalled.
- Throughput: 1 word/cycle.
- While out_valid && !out_ready: out_data and out_valid held stable; at most 2 words buffered; no loss, no duplication, order preserved.
- out_valid may drop only after a transfer.
- word_count increments on each out_valid && out_ready edge.

Test Plan:
- Defaults N=32, M=8.
- LSB offset 4, sign_ext=0, in 0x12345678 -> out_data 0x67, out_valid 2 cycles after in_valid; word_count=1 after transfer.
- MSB offset 0 then offset 28, in 0x12345678 -> 0x12, then 0x80 (in[3:0]=0x8, low nibble zero-filled).
- LSB offset 28, in 0x80000000: sign_ext=1 -> 0xF8; sign_ext=0 -> 0x08.
- Stream 0x1..0x6 back-to-back, out_ready low for 5 cycles mid-stream:
  - in_ready drops after 2 words are buffered.
  - Outputs are exactly 6 words in order.
  - out_data stable while stalled.
- cfg_load offset 8 in the same cycle word A is accepted, word B next cycle -> A sliced with old offset, B with offset 8.
- cfg_load offset 32 -> cfg_err high 1 cycle, slices unchanged.
- rst pulsed with 2 words in flight -> out_valid=0 immediately, no stale word after release.
- 65536 transfers -> word_count wraps to 0.

Source files
------------

// File: rtl/slice_stream.sv
// Streaming runtime-configurable bit slicer: two registered stages with valid/ready
// on both sides; each word carries its own snapshot of the active slice config.
module slice_stream #(
    parameter int DATA_WIDTH    = 32,
    parameter int OUT_WIDTH     = 8,
    parameter int OFFSET_WIDTH  = 5,
    parameter bit RESET_REL_MSB = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic                    cfg_rel_msb,
    input  logic                    cfg_sign_ext,
    input  logic                    cfg_load,
    output logic                    cfg_err,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             word_count
);

    localparam logic [OFFSET_WIDTH:0] OFFSET_LIMIT = (OFFSET_WIDTH + 1)'(DATA_WIDTH);

    // Active configuration
    logic [OFFSET_WIDTH-1:0] act_offset_q;
    logic                    act_rel_msb_q;
    logic                    act_sign_ext_q;
    logic                    cfg_err_q;

    // Stage 1: word plus the config it was accepted under
    logic                    s1_valid_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic [OFFSET_WIDTH-1:0] s1_offset_q;
    logic                    s1_rel_msb_q;
    logic                    s1_sign_ext_q;

    // Stage 2: registered output
    logic                    out_valid_q;
    logic [OUT_WIDTH-1:0]    out_data_q;
    logic [OUT_WIDTH-1:0]    out_data_d;
    logic [15:0]             word_count_q;

    logic cfg_ok;
    logic s1_adv;
    logic accept;
    logic fill_bit;

    assign cfg_ok   = ({1'b0, cfg_offset} < OFFSET_LIMIT);
    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;
    assign fill_bit = s1_sign_ext_q & s1_data_q[DATA_WIDTH-1];

    // Padded shifts keep every index in range: LSB mode pads above the word with
    // the fill bit, MSB mode pads below it with zeros and takes the top OUT_WIDTH bits.
    always_comb begin
        out_data_d = '0;
        if (s1_rel_msb_q) begin
            out_data_d = OUT_WIDTH'(({s1_data_q, {OUT_WIDTH{1'b0}}} << s1_offset_q) >> DATA_WIDTH);
        end else begin
            out_data_d = OUT_WIDTH'({{DATA_WIDTH{fill_bit}}, s1_data_q} >> s1_offset_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values; the stage-1 capture below relies on reading the old config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_offset_q   <= '0;
            act_rel_msb_q  <= RESET_REL_MSB;
            act_sign_ext_q <= 1'b0;
            cfg_err_q      <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s1_offset_q    <= '0;
            s1_rel_msb_q   <= 1'b0;
            s1_sign_ext_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            word_count_q   <= '0;
        end else begin
            cfg_err_q <= cfg_load && !cfg_ok;
            if (cfg_load && cfg_ok) begin
                act_offset_q   <= cfg_offset;
                act_rel_msb_q  <= cfg_rel_msb;
                act_sign_ext_q <= cfg_sign_ext;
            end

            if (accept) begin
                s1_valid_q    <= 1'b1;
                s1_data_q     <= in_data;
                s1_offset_q   <= act_offset_q;
                s1_rel_msb_q  <= act_rel_msb_q;
                s1_sign_ext_q <= act_sign_ext_q;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            // Output only changes on a move from stage 1 or after a completed transfer
            if (s1_adv) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && out_ready) begin
                word_count_q <= word_count_q + 16'd1;
            end
        end
    end

    assign cfg_err    = cfg_err_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_slice_stream.sv
// Bench for slice_stream: directed vector table, multi-cycle corner sequences and
// randomized traffic scored against a bit-rule reference model with an ordered queue.
module tb_slice_stream;

    localparam int N  = 32;
    localparam int M  = 8;
    localparam int OW = 6;

    logic          clk;
    logic          rst;
    logic [OW-1:0] cfg_offset;
    logic          cfg_rel_msb;
    logic          cfg_sign_ext;
    logic          cfg_load;
    logic          cfg_err;
    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   word_count;

    slice_stream #(
        .DATA_WIDTH   (N),
        .OUT_WIDTH    (M),
        .OFFSET_WIDTH (OW),
        .RESET_REL_MSB(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_offset  (cfg_offset),
        .cfg_rel_msb (cfg_rel_msb),
        .cfg_sign_ext(cfg_sign_ext),
        .cfg_load    (cfg_load),
        .cfg_err     (cfg_err),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           load;
        logic [OW-1:0] off;
        bit           msb;
        bit           se;
        logic [N-1:0] din;
        logic [M-1:0] exp;
    } vec_t;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [M-1:0] exp_q[$];
    logic [M-1:0] got_q[$];
    int           m_off;
    bit           m_msb;
    bit           m_se;
    logic [15:0]  m_wc;
    int           xfer_total;
    bit           stalled_prev;
    logic [M-1:0] held_data;
    bit           last_acc;
    bit           last_in_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [M-1:0] model_slice(input logic [N-1:0] d, input int o,
                                                  input bit msb, input bit se);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            if (!msb) begin
                if (o + i <= N - 1) r[i] = d[o+i];
                else                r[i] = se ? d[N-1] : 1'b0;
            end else begin
                if (N - 1 - o - i >= 0) r[M-1-i] = d[N-1-o-i];
                else                    r[M-1-i] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_off        = 0;
        m_msb        = 1'b1;
        m_se         = 1'b0;
        m_wc         = '0;
        xfer_total   = 0;
        stalled_prev = 1'b0;
    endtask

    // One clock: inputs are set by the caller at the falling edge; observe, update
    // the model with what the coming rising edge will do, then check the aftermath.
    task automatic tick();
        int           cnt;
        bit           acc;
        bit           xfer;
        bit           err_next;
        logic [M-1:0] e;
        #1;
        cnt = exp_q.size();
        check("in_ready", {31'b0, in_ready}, {31'b0, (cnt < 2) || out_ready});
        if (out_valid) check("no_spurious", cnt, (cnt == 0) ? 1 : cnt);
        if (cnt == 2) check("full_valid", {31'b0, out_valid}, 32'd1);
        if (stalled_prev) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", {24'b0, out_data}, {24'b0, held_data});
        end
        xfer = out_valid && out_ready;
        acc  = in_valid && in_ready;
        if (xfer) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("out_data", {24'b0, out_data}, {24'b0, e});
            got_q.push_back(out_data);
            m_wc = m_wc + 16'd1;
            xfer_total++;
        end
        if (acc) exp_q.push_back(model_slice(in_data, m_off, m_msb, m_se));
        stalled_prev  = out_valid && !out_ready;
        held_data     = out_data;
        last_acc      = acc;
        last_in_ready = in_ready;
        err_next      = cfg_load && (int'(cfg_offset) >= N);
        if (cfg_load && !err_next) begin
            m_off = int'(cfg_offset);
            m_msb = cfg_rel_msb;
            m_se  = cfg_sign_ext;
        end
        @(posedge clk);
        @(negedge clk);
        check("cfg_err", {31'b0, cfg_err}, {31'b0, err_next});
        check("word_count", {16'b0, word_count}, {16'b0, m_wc});
    endtask

    task automatic load_cfg(input int off, input bit msb, input bit se);
        cfg_load     = 1'b1;
        cfg_offset   = OW'(off);
        cfg_rel_msb  = msb;
        cfg_sign_ext = se;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_word_count", {16'b0, word_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b0, 6'd0,  1'b1, 1'b0, 32'h12345678, 8'h12};
        tbl[1]  = '{1'b1, 6'd4,  1'b0, 1'b0, 32'h12345678, 8'h67};
        tbl[2]  = '{1'b1, 6'd0,  1'b1, 1'b0, 32'h12345678, 8'h12};
        tbl[3]  = '{1'b1, 6'd28, 1'b1, 1'b0, 32'h12345678, 8'h80};
        tbl[4]  = '{1'b1, 6'd28, 1'b0, 1'b1, 32'h80000000, 8'hF8};
        tbl[5]  = '{1'b1, 6'd28, 1'b0, 1'b0, 32'h80000000, 8'h08};
        tbl[6]  = '{1'b1, 6'd0,  1'b0, 1'b1, 32'h000000A5, 8'hA5};
        tbl[7]  = '{1'b1, 6'd31, 1'b1, 1'b0, 32'h00000001, 8'h80};
        tbl[8]  = '{1'b1, 6'd31, 1'b0, 1'b1, 32'h80000000, 8'hFF};
        tbl[9]  = '{1'b1, 6'd31, 1'b0, 1'b0, 32'h80000000, 8'h01};
        tbl[10] = '{1'b1, 6'd26, 1'b0, 1'b1, 32'h80000000, 8'hE0};
        tbl[11] = '{1'b1, 6'd4,  1'b1, 1'b1, 32'h0ABCDEF0, 8'hAB};
        tbl[12] = '{1'b1, 6'd24, 1'b0, 1'b1, 32'h7F000000, 8'h7F};

        rst = 1'b1;
        cfg_offset = '0; cfg_rel_msb = 1'b0; cfg_sign_ext = 1'b0; cfg_load = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", {24'b0, out_data}, 32'd0);
        check("reset_cfg_err", {31'b0, cfg_err}, 32'd0);
        check("reset_word_count", {16'b0, word_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed vectors with latency checks
        foreach (tbl[i]) begin
            out_ready = 1'b1;
            if (tbl[i].load) load_cfg(int'(tbl[i].off), tbl[i].msb, tbl[i].se);
            else tick();
            in_valid = 1'b1;
            in_data  = tbl[i].din;
            tick();
            in_valid = 1'b0;
            check("accepted", {31'b0, last_acc}, 32'd1);
            check("lat_early", {31'b0, out_valid}, 32'd0);
            tick();
            check("lat_valid", {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d", i), {24'b0, out_data}, {24'b0, tbl[i].exp});
            tick();
            if (i == 0) check("wc_first", {16'b0, word_count}, 32'd1);
        end

        // Back-to-back stream 1..6 with a 5-cycle downstream stall
        begin
            int idx = 0;
            bit saw_block = 1'b0;
            load_cfg(0, 1'b0, 1'b0);
            got_q.delete();
            for (int cyc = 0; cyc < 40 && got_q.size() < 6; cyc++) begin
                in_valid  = (idx < 6);
                in_data   = N'(idx + 1);
                out_ready = !(cyc >= 2 && cyc < 7);
                tick();
                if (!last_in_ready) saw_block = 1'b1;
                if (last_acc) idx++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("stall_ready_drop", {31'b0, saw_block}, 32'd1);
            check("stall_count", got_q.size(), 32'd6);
            for (int i = 0; i < 6 && i < got_q.size(); i++)
                check($sformatf("stall_word%0d", i), {24'b0, got_q[i]}, i + 1);
        end

        // Config load in the same cycle as word A; word B sees the new offset
        load_cfg(0, 1'b0, 1'b0);
        got_q.delete();
        cfg_load = 1'b1; cfg_offset = 6'd8; cfg_rel_msb = 1'b0; cfg_sign_ext = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000AB12;
        tick();
        cfg_load = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && got_q.size() < 2; k++) tick();
        check("samecyc_count", got_q.size(), 32'd2);
        if (got_q.size() >= 2) begin
            check("samecyc_old", {24'b0, got_q[0]}, 32'h12);
            check("samecyc_new", {24'b0, got_q[1]}, 32'hAB);
        end

        // Rejected load: one-cycle error pulse, config unchanged
        load_cfg(32, 1'b1, 1'b1);
        check("err_pulse", {31'b0, cfg_err}, 32'd1);
        tick();
        check("err_clear", {31'b0, cfg_err}, 32'd0);
        got_q.delete();
        in_valid = 1'b1; in_data = 32'h0000AB12;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && got_q.size() < 1; k++) tick();
        check("err_keep_cfg", (got_q.size() > 0) ? {24'b0, got_q[0]} : 32'hDEAD, 32'hAB);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11111111;
        tick();
        in_data   = 32'h22222222;
        tick();
        in_valid  = 1'b0;
        check("inflight_valid", {31'b0, out_valid}, 32'd1);
        pulse_reset();
        out_ready = 1'b1;
        repeat (4) begin
            tick();
            check("no_stale", {31'b0, out_valid}, 32'd0);
        end

        // Randomized traffic, configs and rejected loads against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 70);
            cfg_load  = ($urandom_range(0, 99) < 5);
            cfg_offset   = OW'($urandom_range(0, 63));
            cfg_rel_msb  = 1'($urandom);
            cfg_sign_ext = 1'($urandom);
            tick();
        end
        cfg_load  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
        check("drain_empty", exp_q.size(), 32'd0);

        // Word counter wrap after 65536 transfers
        pulse_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 65600 && xfer_total < 65536; k++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        check("wrap_transfers", xfer_total, 32'd65536);
        check("wrap_count", {16'b0, word_count}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
